// File: rtl/udiv_pkg.sv
// udiv_pkg: shared state encoding and sizing helper for the iterative divider
package udiv_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  function automatic int clog2(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return w;
  endfunction
endpackage

// File: rtl/udiv_step.sv
// udiv_step: one combinational restoring-division step
module udiv_step #(
  parameter int ND = 32
) (
  input  logic [ND:0]   r,
  input  logic          q_msb,
  input  logic [ND-1:0] d,
  output logic [ND:0]   r_next,
  output logic          q_bit
);
  logic [ND:0] t;
  always_comb begin
    t = {r[ND-1:0], q_msb};
    q_bit = t >= {1'b0, d};
    r_next = q_bit ? t - {1'b0, d} : t;
  end
endmodule

// File: rtl/udiv_32x32.sv
// udiv_32x32: iterative restoring unsigned divider, one quotient bit per enabled clock
module udiv_32x32
  import udiv_pkg::*;
#(
  parameter int NN = 32,
  parameter int ND = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_wr,
  input  logic [NN-1:0] i_numerator,
  input  logic [ND-1:0] i_denominator,
  input  logic          i_aux,
  output logic          o_busy,
  output logic          o_valid,
  output logic          o_err,
  output logic [NN-1:0] o_quotient,
  output logic [ND-1:0] o_remainder,
  output logic          o_aux
);
  localparam int CW = clog2(NN + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [NN-1:0] q;
  logic [ND:0] r, r_next;
  logic [ND-1:0] d;
  logic aux, q_bit, accept, run_step, done, den_zero;
  udiv_step #(.ND(ND)) u_step (
    .r(r), .q_msb(q[NN-1]), .d(d), .r_next(r_next), .q_bit(q_bit)
  );
  assign o_busy = state == ST_RUN;
  always_comb begin
    den_zero = i_denominator == '0;
    accept = i_ce && i_wr && !o_busy;
    run_step = o_busy && i_ce;
    done = run_step && cnt == CW'(1);
    state_n = (accept && !den_zero) ? ST_RUN : done ? ST_IDLE : state;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      q <= '0;
      r <= '0;
      d <= '0;
      aux <= 1'b0;
      o_valid <= 1'b0;
      o_err <= 1'b0;
      o_quotient <= '0;
      o_remainder <= '0;
      o_aux <= 1'b0;
    end else begin
      state <= state_n;
      o_valid <= 1'b0;
      o_err <= 1'b0;
      o_aux <= 1'b0;
      if (accept) begin
        q <= i_numerator;
        d <= i_denominator;
        aux <= i_aux;
        r <= '0;
        if (den_zero) begin
          o_valid <= 1'b1;
          o_err <= 1'b1;
          o_quotient <= '1;
          o_remainder <= i_numerator[ND-1:0];
          o_aux <= i_aux;
        end else begin
          cnt <= CW'(NN);
        end
      end else if (run_step) begin
        q <= {q[NN-2:0], q_bit};
        r <= r_next;
        cnt <= cnt - 1'b1;
        if (done) begin
          o_valid <= 1'b1;
          o_quotient <= {q[NN-2:0], q_bit};
          o_remainder <= r_next[ND-1:0];
          o_aux <= aux;
        end
      end
    end
  end
endmodule

// File: doc/udiv_32x32.md
Name: udiv_32x32

Overview:
- Unsigned iterative restoring divider, the inverse operation to the team's pipelined unsigned multipliers.
- Computes quotient and remainder of an NN-bit numerator by an ND-bit denominator, one quotient bit per i_ce-qualified clock.
- Start/busy/valid handshake, plus an aux bit carried alongside each operation.
- Sits beside the multiply cores in the arithmetic library for datapaths that need multiply and divide.

Parameters:
- NN, 32, numerator and quotient width.
- ND, 32, denominator and remainder width (ND <= NN).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_ce  in  1  clock enable; advances iteration steps only
- i_wr  in  1  start request
- i_numerator  in  NN  dividend, sampled on accept
- i_denominator  in  ND  divisor, sampled on accept
- i_aux  in  1  side bit, sampled on accept
- o_busy  out  1  division in progress
- o_valid  out  1  one-clock result strobe
- o_err  out  1  divide-by-zero flag, qualified by o_valid
- o_quotient  out  NN  quotient
- o_remainder  out  ND  remainder
- o_aux  out  1  i_aux of the completing operation, qualified by o_valid

Behaviour:
- Reset and clock: reset i_reset, synchronous, active-high; clock i_clk.
- Reset values: all outputs 0, state IDLE, step counter 0. Initial values match reset values.
- Reset mid-operation aborts the division. No o_valid is produced for it. State returns to IDLE on that edge.
- States: IDLE, RUN.
- Accept: on a clock edge with i_ce && i_wr && !o_busy, the block latches the numerator into the working quotient shift register, the denominator, i_aux, and clears the partial remainder (ND+1 bits).
  - Denominator != 0: go to RUN, set o_busy=1, set counter=NN.
  - Denominator == 0: stay in IDLE. On that same edge set o_valid=1, o_err=1, o_quotient={NN{1'b1}}, o_remainder=i_numerator[ND-1:0], o_aux=i_aux.
- i_wr with o_busy=1 is ignored; no queueing.
- i_wr on the cycle o_valid is high is accepted, because o_busy is already 0.
- RUN step, on each edge with i_ce:
  - t = {r[ND-1:0], q[NN-1]}; q <<= 1.
  - If t >= {1'b0,d}: r = t - d and q[0] = 1. Else r = t and q[0] = 0.
  - Decrement the counter.
- RUN with i_ce low: all state holds.
- On the step edge where the counter goes 1 -> 0, the same edge:
  - o_quotient = final q, o_remainder = r[ND-1:0].
  - o_valid=1, o_err=0, o_aux = latched aux.
  - o_busy=0, state to IDLE.
- Latency: exactly NN i_ce-high edges after the accept edge (32 by default). o_busy stays high for that span.
- o_valid and o_aux clear on the next clock edge regardless of i_ce, unless a new divide-by-zero accept re-raises them. o_err clears together with o_valid.
- o_quotient and o_remainder hold the last result until the next completion. Intermediate working values are never visible on them.
- Invariant on every non-error o_valid: o_quotient*d + o_remainder == n and o_remainder < d.
- Formal properties:
  - o_valid && !o_err implies the invariant above.
  - o_busy and o_valid are never both high.
  - o_busy falls exactly when o_valid rises, or on reset.

Decomposition:
- Shared package udiv_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_RUN=1'b1;
  - counter width function clog2(NN+1).
- One natural sub-module, udiv_step: purely combinational single restoring step.
  - Inputs: r (ND+1), q msb, d (ND).
  - Outputs: next r, quotient bit.
  - Lets a future unrolled or pipelined variant instantiate it per stage.

Test Plan:
- Basic: n=100, d=7 -> o_valid 32 i_ce-edges after accept, q=14, r=2, err=0, o_busy high for exactly those 32 cycles.
- Extremes: n=0xFFFFFFFF, d=1 -> q=0xFFFFFFFF, r=0. Second case n=5, d=0xFFFFFFFF -> q=0, r=5. i_aux=1 on the first returns o_aux=1 only on its o_valid cycle.
- Divide by zero: n=5, d=0 -> one edge after accept o_valid=1, o_err=1, q=0xFFFFFFFF, r=5, o_busy never asserts.
- Stall and overlap:
  - n=1000, d=10 with i_ce toggling every other clock -> q=100, r=0 after 32 i_ce-high edges, outputs stable during stalls.
  - i_wr (n=9, d=3) pulsed mid-run is ignored.
  - i_wr held on the o_valid cycle starts a back-to-back op giving q=3, r=0.
- Reset mid-run: assert i_reset at step 10 of n=77, d=5 -> next edge o_busy=0, o_valid=0, outputs 0, no later o_valid. A fresh 77/5 afterwards gives q=15, r=2.
- Random: 10k random n/d pairs (d nonzero, biased toward small d and 2^k values) checked against the invariant and a reference division model.
